// File: rtl/rect_to_cyl_cordic_pkg.sv
// Shared types, constants and the arctangent table generator for the
// rectangular-to-cylindrical CORDIC converter.
package rect_to_cyl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROT   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 1/1.64676 in Q0.16: removes the CORDIC gain from the final x.
    localparam logic [15:0] K_INV = 16'd39797;

    // atan(2^-i) as a fraction of a full turn, rounded to 'width' bits.
    // Reference values are in units of 2^-32 turn; beyond i=9 atan(x)~x.
    function automatic logic [31:0] atan_lut(input int i, input int width);
        logic [31:0] v;
        logic [32:0] s;
        case (i)
            0: v = 32'd536870912;
            1: v = 32'd316933406;
            2: v = 32'd167458907;
            3: v = 32'd85004756;
            4: v = 32'd42667331;
            5: v = 32'd21354465;
            6: v = 32'd10679838;
            7: v = 32'd5340245;
            8: v = 32'd2670163;
            9: v = 32'd1335087;
            default: v = 32'd683565276 >> i;
        endcase
        s = {1'b0, v} + (33'd1 << (31 - width));
        return 32'(s >> (32 - width));
    endfunction

endpackage

// File: rtl/rect_to_cyl_cordic_if.sv
// Sample-in / result-out handshake bundle for the CORDIC converter.
interface rect_to_cyl_cordic_if #(
    parameter int WIDTH   = 8,
    parameter int ANGLE_W = 8
);
    // Both sides use valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both high; valid may not depend on ready.
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   x_in;
    logic signed [WIDTH-1:0]   y_in;
    logic        [WIDTH-1:0]   z_in;
    logic                      out_valid;
    logic                      out_ready;
    logic        [WIDTH-1:0]   r_out;
    logic        [ANGLE_W-1:0] theta_out;
    logic        [WIDTH-1:0]   z_out;

    modport master (
        output in_valid, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, r_out, theta_out, z_out
    );

    modport slave (
        input  in_valid, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, r_out, theta_out, z_out
    );
endinterface

// File: rtl/rect_to_cyl_cordic_atan_rom.sv
// Combinational arctangent table: micro-rotation index -> atan(2^-i) in
// binary-angle units of 2^AW per turn.
module cordic_atan_rom
    import rect_to_cyl_pkg::*;
#(
    parameter int AW   = 10,
    parameter int ITER = 8,
    parameter int IW   = 4
) (
    input  logic [IW-1:0] i_idx,
    output logic [AW-1:0] o_atan
);

    logic [AW-1:0] w_table [ITER];

    for (genvar k = 0; k < ITER; k++) begin : g_tab
        localparam logic [31:0] LV = atan_lut(k, AW);
        assign w_table[k] = LV[AW-1:0];
    end

    always_comb begin
        o_atan = '0;
        for (int k = 0; k < ITER; k++) begin
            if (int'(i_idx) == k) o_atan = w_table[k];
        end
    end

endmodule

// File: rtl/rect_to_cyl_cordic.sv
// Iterative vectoring-mode CORDIC: (x,y,z) -> (r,theta,z), one
// micro-rotation per clock between an input and an output handshake.
module rect_to_cyl_cordic
    import rect_to_cyl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ANGLE_W = 8,
    parameter int ITER    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rect_to_cyl_cordic_if.slave  bus,
    output state_t               o_dbg_state
);

    // Fractional guard bits below the integer LSB keep shift truncation out
    // of the result; the two extra integer bits cover the CORDIC gain.
    localparam int FRAC = ITER + 4;
    localparam int XW   = WIDTH + 2 + FRAC;
    localparam int AWI  = ANGLE_W + 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam int PW   = XW + 16;
    localparam int RW   = WIDTH + 2;
    localparam logic [AWI-1:0] HALF_TURN = {1'b1, {(AWI-1){1'b0}}};

    state_t                r_state;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [AWI-1:0]        r_z_acc;
    logic [CW-1:0]         r_iter;
    logic [WIDTH-1:0]      r_zin;
    logic                  r_zero;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_r_out;
    logic [ANGLE_W-1:0]    r_theta_out;
    logic [WIDTH-1:0]      r_z_out;

    logic signed [XW-1:0]  w_x_ext;
    logic signed [XW-1:0]  w_y_ext;
    logic signed [XW-1:0]  w_x_sh;
    logic signed [XW-1:0]  w_y_sh;
    logic                  w_d;
    logic [AWI-1:0]        w_atan;
    logic [XW-1:0]         w_x_mag;
    logic [PW-1:0]         w_prod;
    logic [RW-1:0]         w_r_full;
    logic [WIDTH-1:0]      w_r_sat;
    logic [AWI-1:0]        w_theta_rnd;
    logic [ANGLE_W-1:0]    w_theta;
    logic                  w_accept;

    assign w_x_ext = {{2{bus.x_in[WIDTH-1]}}, bus.x_in, {FRAC{1'b0}}};
    assign w_y_ext = {{2{bus.y_in[WIDTH-1]}}, bus.y_in, {FRAC{1'b0}}};
    assign w_x_sh  = r_x >>> r_iter;
    assign w_y_sh  = r_y >>> r_iter;
    assign w_d     = ~r_y[XW-1];

    cordic_atan_rom #(
        .AW   (AWI),
        .ITER (ITER),
        .IW   (CW)
    ) u_atan_rom (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    // x stays non-negative after the fold; the clamp only guards the multiplier.
    assign w_x_mag     = r_x[XW-1] ? '0 : r_x;
    assign w_prod      = PW'(w_x_mag) * PW'(K_INV);
    assign w_r_full    = RW'(w_prod >> (16 + FRAC));
    assign w_r_sat     = (|w_r_full[RW-1:WIDTH]) ? '1 : w_r_full[WIDTH-1:0];
    assign w_theta_rnd = r_z_acc + AWI'(2);
    assign w_theta     = ANGLE_W'(w_theta_rnd >> 2);

    assign w_accept = bus.in_valid && r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z_acc     <= '0;
            r_iter      <= '0;
            r_zin       <= '0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_r_out     <= '0;
            r_theta_out <= '0;
            r_z_out     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Fold the left half-plane onto the right so the
                        // rotations only have to cover +/-90 degrees.
                        if (bus.x_in[WIDTH-1]) begin
                            r_x     <= -w_x_ext;
                            r_y     <= -w_y_ext;
                            r_z_acc <= HALF_TURN;
                        end else begin
                            r_x     <= w_x_ext;
                            r_y     <= w_y_ext;
                            r_z_acc <= '0;
                        end
                        r_iter     <= '0;
                        r_zin      <= bus.z_in;
                        r_zero     <= (bus.x_in == '0) && (bus.y_in == '0);
                        r_in_ready <= 1'b0;
                        r_state    <= ROT;
                    end
                end
                ROT: begin
                    r_x     <= w_d ? r_x + w_y_sh : r_x - w_y_sh;
                    r_y     <= w_d ? r_y - w_x_sh : r_y + w_x_sh;
                    r_z_acc <= w_d ? r_z_acc + w_atan : r_z_acc - w_atan;
                    r_iter  <= r_iter + CW'(1);
                    if (r_iter == CW'(ITER - 1)) r_state <= SCALE;
                end
                SCALE: begin
                    r_r_out     <= r_zero ? '0 : w_r_sat;
                    r_theta_out <= r_zero ? '0 : w_theta;
                    r_z_out     <= r_zin;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.r_out     = r_r_out;
    assign bus.theta_out = r_theta_out;
    assign bus.z_out     = r_z_out;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rect_to_cyl_cordic.sv
// Directed and randomized checks of rect_to_cyl_cordic against a real-valued
// atan2/hypot reference model.
module tb_rect_to_cyl_cordic;
    import rect_to_cyl_pkg::*;

    localparam int  WIDTH   = 8;
    localparam int  ANGLE_W = 8;
    localparam int  ITER    = 8;
    localparam real PI      = 3.14159265358979323846;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    always #5 clk = ~clk;

    rect_to_cyl_cordic_if #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W)) bus ();

    rect_to_cyl_cordic #(
        .WIDTH   (WIDTH),
        .ANGLE_W (ANGLE_W),
        .ITER    (ITER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [3*WIDTH-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // modn=0: plain difference; otherwise circular difference modulo modn.
    task automatic check_tol(input string tag, input int obs, input int exp,
                             input int tol, input int modn);
        int  d;
        bit  ok;
        d = obs - exp;
        if (modn != 0) begin
            d = ((d % modn) + modn) % modn;
            if (d > modn / 2) d = modn - d;
        end
        if (d < 0) d = -d;
        ok = (d <= tol);
        n_vec++;
        assert (ok === 1'b1) else begin
            n_miss++;
            $error("FAIL %s: observed %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_r(input int x, input int y);
        real m;
        m = $sqrt(real'(x * x + y * y));
        return $rtoi(m + 0.5);
    endfunction

    function automatic int model_theta(input int x, input int y);
        real a;
        int  t;
        if (x == 0 && y == 0) return 0;
        a = $atan2(real'(y), real'(x));
        if (a < 0.0) a = a + 2.0 * PI;
        t = $rtoi(a / (2.0 * PI) * real'(1 << ANGLE_W) + 0.5);
        return t % (1 << ANGLE_W);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int x, input int y, input int z);
        exp_q.push_back({WIDTH'(model_r(x, y)), ANGLE_W'(model_theta(x, y)), WIDTH'(z)});
    endtask

    task automatic drive_in(input int x, input int y, input int z);
        bus.x_in     = WIDTH'(x);
        bus.y_in     = WIDTH'(y);
        bus.z_in     = WIDTH'(z);
        bus.in_valid = 1'b1;
    endtask

    // Waits for the accept edge; in_valid is left as it is.
    task automatic wait_accept(input string tag);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = bus.in_ready;
            tick();
            n++;
        end
        check({tag, "_accept"}, int'(acc), 1);
    endtask

    task automatic wait_out(input string tag, output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 60) begin
            tick();
            cycles++;
        end
        check({tag, "_out_valid"}, int'(bus.out_valid), 1);
    endtask

    task automatic check_result(input string tag, input bit zero);
        logic [3*WIDTH-1:0] e;
        int tol;
        tol = zero ? 0 : 1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_tol({tag, "_r"}, int'(bus.r_out), int'(e[3*WIDTH-1:2*WIDTH]), tol, 0);
            check_tol({tag, "_theta"}, int'(bus.theta_out), int'(e[2*WIDTH-1:WIDTH]),
                      tol, 1 << ANGLE_W);
            check({tag, "_z"}, int'(bus.z_out), int'(e[WIDTH-1:0]));
        end
    endtask

    task automatic handshake_out(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
        check({tag, "_out_valid_drop"}, int'(bus.out_valid), 0);
    endtask

    task automatic run_vec(input string tag, input int x, input int y, input int z,
                           input int hold, input bit chk_lat);
        int cyc;
        push_exp(x, y, z);
        drive_in(x, y, z);
        wait_accept(tag);
        bus.in_valid = 1'b0;
        wait_out(tag, cyc);
        if (chk_lat) check({tag, "_latency"}, cyc, ITER + 1);
        repeat (hold) tick();
        check_result(tag, (x == 0 && y == 0));
        handshake_out(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        bit rdy_seen;
        bit unstable;
        logic [WIDTH-1:0]   hold_r;
        logic [ANGLE_W-1:0] hold_t;
        logic [WIDTH-1:0]   hold_z;
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        int corner[4];

        corner[0] = -128; corner[1] = 127; corner[2] = 0; corner[3] = -1;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.z_in      = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_r", int'(bus.r_out), 0);
        check("rst_theta", int'(bus.theta_out), 0);
        check("rst_z", int'(bus.z_out), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));

        // Directed vectors from the datasheet table
        run_vec("v3_4", 3, 4, 7, 0, 1'b1);
        run_vec("v0_5", 0, 5, 11, 0, 1'b1);
        run_vec("vm128_0", -128, 0, 200, 0, 1'b1);
        run_vec("vm5_m5", -5, -5, 33, 1, 1'b0);
        run_vec("v0_m100", 0, -100, 99, 0, 1'b0);
        run_vec("vm128_m128", -128, -128, 128, 0, 1'b0);
        run_vec("v127_127", 127, 127, 1, 0, 1'b0);
        run_vec("vm128_127", -128, 127, 2, 0, 1'b0);
        run_vec("v127_m128", 127, -128, 3, 0, 1'b0);
        run_vec("wrap_lo", 100, -1, 4, 0, 1'b0);
        run_vec("wrap_hi", 100, 1, 5, 0, 1'b0);
        run_vec("zero", 0, 0, 77, 0, 1'b1);

        // in_valid held high across a conversion: second sample waits for DONE
        push_exp(20, -30, 17);
        drive_in(20, -30, 17);
        wait_accept("b2b_a");
        drive_in(-40, 9, 18);
        rdy_seen = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 60) begin
            rdy_seen |= bus.in_ready;
            tick();
            cyc++;
        end
        repeat (3) begin
            rdy_seen |= bus.in_ready;
            tick();
        end
        check("b2b_in_ready_low", int'(rdy_seen), 0);
        check("b2b_a_out_valid", int'(bus.out_valid), 1);
        check_result("b2b_a", 1'b0);
        push_exp(-40, 9, 18);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("b2b_in_ready_back", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_b_accepted", int'(dbg_state), int'(ROT));
        wait_out("b2b_b", cyc);
        check_result("b2b_b", 1'b0);
        handshake_out("b2b_b");

        // Back-pressure: result must hold steady while out_ready is low
        push_exp(-77, 55, 66);
        drive_in(-77, 55, 66);
        wait_accept("bp");
        bus.in_valid = 1'b0;
        wait_out("bp", cyc);
        hold_r   = bus.r_out;
        hold_t   = bus.theta_out;
        hold_z   = bus.z_out;
        unstable = 1'b0;
        repeat (20) begin
            tick();
            if (!bus.out_valid || bus.r_out !== hold_r || bus.theta_out !== hold_t ||
                bus.z_out !== hold_z || bus.in_ready) unstable = 1'b1;
        end
        check("bp_stable", int'(unstable), 0);
        check_result("bp", 1'b0);
        handshake_out("bp");
        check("bp_idle", int'(dbg_state), int'(IDLE));

        // Reset during the rotations: outputs must clear immediately
        drive_in(50, 60, 90);
        wait_accept("rst_mid");
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("rst_mid_in_rot", int'(dbg_state), int'(ROT));
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_r", int'(bus.r_out), 0);
        check("rst_mid_theta", int'(bus.theta_out), 0);
        check("rst_mid_z", int'(bus.z_out), 0);
        check("rst_mid_in_ready", int'(bus.in_ready), 1);
        check("rst_mid_state", int'(dbg_state), int'(IDLE));
        tick();
        rst = 1'b0;
        tick();
        run_vec("after_rst", -9, 14, 123, 0, 1'b1);

        // Randomized vectors, biased towards the extremes every few samples
        for (int k = 0; k < 1500; k++) begin
            sx = WIDTH'($urandom_range(0, 255));
            sy = WIDTH'($urandom_range(0, 255));
            if (k % 8 == 0) sx = WIDTH'(corner[$urandom_range(0, 3)]);
            if (k % 8 == 4) sy = WIDTH'(corner[$urandom_range(0, 3)]);
            run_vec("rand", int'(sx), int'(sy), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)), 1'b0);
        end

        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
